// File: rtl/sdf_bf_stage_8.sv
// Radix-2 butterfly and sequencing for the 8-deep stage of a 32-point SDF FFT.
// The 8-entry delay line is external: this block drives its write port/enable and reads its tap.
module sdf_bf_stage_8 #(
  parameter int DW   = 24,
  parameter int HALF = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] din_r,
  input  logic [DW-1:0] din_i,
  input  logic [DW-1:0] delay_out_r,
  input  logic [DW-1:0] delay_out_i,
  output logic [DW-1:0] delay_in_r,
  output logic [DW-1:0] delay_in_i,
  output logic          delay_en,
  output logic          out_valid,
  output logic [DW-1:0] dout_r,
  output logic [DW-1:0] dout_i,
  output logic          is_diff,
  output logic [2:0]    tw_idx,
  output logic          err
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  localparam logic [3:0] LAST_FLUSH = 4'(HALF - 32'sd1);

  state_t          state_r;
  state_t          state_nxt_s;
  logic [3:0]      cnt_r;
  logic [3:0]      cnt_nxt_s;
  logic            primed_r;
  logic            primed_nxt_s;
  logic            accept_s;
  logic            flush_s;
  logic            drop_s;
  logic            bfly_s;
  logic            out_valid_nxt_s;
  logic            is_diff_nxt_s;
  logic [2:0]      tw_idx_nxt_s;
  logic [DW-1:0]   dout_r_nxt_s;
  logic [DW-1:0]   dout_i_nxt_s;
  logic [DW-1:0]   sum_r_s;
  logic [DW-1:0]   sum_i_s;
  logic [DW-1:0]   dif_r_s;
  logic [DW-1:0]   dif_i_s;

  // (a + b) >>> 1 in DW+1 bits; the halved result always fits back into DW bits.
  function automatic logic [DW-1:0] half_add(input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic signed [DW:0] s;
    s = $signed({a[DW-1], a}) + $signed({b[DW-1], b});
    return s[DW:1];
  endfunction

  function automatic logic [DW-1:0] half_sub(input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic signed [DW:0] s;
    s = $signed({a[DW-1], a}) - $signed({b[DW-1], b});
    return s[DW:1];
  endfunction

  assign sum_r_s = half_add(delay_out_r, din_r);
  assign sum_i_s = half_add(delay_out_i, din_i);
  assign dif_r_s = half_sub(delay_out_r, din_r);
  assign dif_i_s = half_sub(delay_out_i, din_i);
  assign bfly_s  = (state_r == ST_RUN) && cnt_r[3];

  // The idle cycle that ends a primed frame already acts as flush slot 0,
  // so stored differences follow the sums without a bubble.
  assign delay_en = rst_n & (accept_s | flush_s);
  assign in_ready = ~rst_n | ~flush_s;

  // Next-state, counter and handshake decode.
  always_comb begin
    state_nxt_s  = state_r;
    cnt_nxt_s    = cnt_r;
    primed_nxt_s = primed_r;
    accept_s     = 1'b0;
    flush_s      = 1'b0;
    drop_s       = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (in_valid) begin
          accept_s    = 1'b1;
          state_nxt_s = ST_RUN;
          cnt_nxt_s   = 4'd1;
        end else begin
          cnt_nxt_s   = 4'd0;
        end
      end
      ST_RUN: begin
        if (in_valid) begin
          accept_s  = 1'b1;
          cnt_nxt_s = cnt_r + 4'd1;
          if (cnt_r == 4'd15) begin
            primed_nxt_s = 1'b1;
          end else begin
            primed_nxt_s = primed_r;
          end
        end else if (cnt_r != 4'd0) begin
          drop_s       = 1'b1;
          state_nxt_s  = ST_IDLE;
          cnt_nxt_s    = 4'd0;
          primed_nxt_s = 1'b0;
        end else if (primed_r) begin
          flush_s     = 1'b1;
          state_nxt_s = ST_FLUSH;
          cnt_nxt_s   = 4'd1;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_FLUSH: begin
        flush_s = 1'b1;
        if (cnt_r == LAST_FLUSH) begin
          state_nxt_s  = ST_IDLE;
          cnt_nxt_s    = 4'd0;
          primed_nxt_s = 1'b0;
        end else begin
          cnt_nxt_s    = cnt_r + 4'd1;
        end
      end
      default: begin
        state_nxt_s  = ST_IDLE;
        cnt_nxt_s    = 4'd0;
        primed_nxt_s = 1'b0;
      end
    endcase
  end

  // Delay-line write data and next registered output values.
  always_comb begin
    delay_in_r      = din_r;
    delay_in_i      = din_i;
    out_valid_nxt_s = 1'b0;
    dout_r_nxt_s    = dout_r;
    dout_i_nxt_s    = dout_i;
    is_diff_nxt_s   = is_diff;
    tw_idx_nxt_s    = tw_idx;
    if (flush_s) begin
      delay_in_r      = {DW{1'b0}};
      delay_in_i      = {DW{1'b0}};
      dout_r_nxt_s    = delay_out_r;
      dout_i_nxt_s    = delay_out_i;
      is_diff_nxt_s   = 1'b1;
      tw_idx_nxt_s    = cnt_r[2:0];
      out_valid_nxt_s = 1'b1;
    end else if (accept_s) begin
      if (bfly_s) begin
        delay_in_r      = dif_r_s;
        delay_in_i      = dif_i_s;
        dout_r_nxt_s    = sum_r_s;
        dout_i_nxt_s    = sum_i_s;
        is_diff_nxt_s   = 1'b0;
        tw_idx_nxt_s    = 3'd0;
        out_valid_nxt_s = 1'b1;
      end else begin
        dout_r_nxt_s    = delay_out_r;
        dout_i_nxt_s    = delay_out_i;
        is_diff_nxt_s   = 1'b1;
        tw_idx_nxt_s    = cnt_r[2:0];
        out_valid_nxt_s = primed_r;
      end
    end else begin
      out_valid_nxt_s = 1'b0;
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      cnt_r     <= 4'd0;
      primed_r  <= 1'b0;
      out_valid <= 1'b0;
      dout_r    <= {DW{1'b0}};
      dout_i    <= {DW{1'b0}};
      is_diff   <= 1'b0;
      tw_idx    <= 3'd0;
      err       <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      cnt_r     <= cnt_nxt_s;
      primed_r  <= primed_nxt_s;
      out_valid <= out_valid_nxt_s;
      dout_r    <= dout_r_nxt_s;
      dout_i    <= dout_i_nxt_s;
      is_diff   <= is_diff_nxt_s;
      tw_idx    <= tw_idx_nxt_s;
      err       <= err | drop_s;
    end
  end

endmodule

// File: tb/tb_sdf_bf_stage_8.sv
// Randomized self-checking bench for sdf_bf_stage_8; the expected output stream is built
// per frame from the butterfly definition and matched against every valid output beat.
module tb_sdf_bf_stage_8;
  localparam int DW = 24;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst_n, in_valid, in_ready, delay_en, out_valid, is_diff, err;
  logic signed [DW-1:0] din_r, din_i, delay_out_r, delay_out_i, delay_in_r, delay_in_i;
  logic signed [DW-1:0] dout_r, dout_i;
  logic [2:0]           tw_idx;

  sdf_bf_stage_8 #(.DW(DW), .HALF(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .din_r(din_r), .din_i(din_i),
    .delay_out_r(delay_out_r), .delay_out_i(delay_out_i),
    .delay_in_r(delay_in_r), .delay_in_i(delay_in_i), .delay_en(delay_en),
    .out_valid(out_valid), .dout_r(dout_r), .dout_i(dout_i),
    .is_diff(is_diff), .tw_idx(tw_idx), .err(err)
  );

  // External 8-entry delay line: tap is the word written 8 enabled cycles earlier.
  logic signed [DW-1:0] dl_r [8];
  logic signed [DW-1:0] dl_i [8];
  always @(posedge clk) begin
    if (delay_en) begin
      dl_r[0] <= delay_in_r;
      dl_i[0] <= delay_in_i;
      for (int k = 1; k < 8; k++) begin
        dl_r[k] <= dl_r[k-1];
        dl_i[k] <= dl_i[k-1];
      end
    end
  end
  assign delay_out_r = dl_r[7];
  assign delay_out_i = dl_i[7];

  typedef struct {
    longint re;
    longint im;
    int     isd;
    int     tw;
  } exp_t;

  exp_t   exp_q[$];
  longint fr_r[16];
  longint fr_i[16];
  int     n_checks = 0;
  int     n_fail   = 0;
  int     cyc = 0, start = 0, first_ov = -1, run_len = 0, last_run = 0, ready_low = 0;
  logic   last_rdy, last_den;

  task automatic check_eq(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Frame model: 8 halved sums, then halved differences tagged with their pair index.
  task automatic push_frame(input int n_diff);
    exp_t e;
    for (int k = 0; k < 8; k++) begin
      e.re = (fr_r[k] + fr_r[k+8]) >>> 1;
      e.im = (fr_i[k] + fr_i[k+8]) >>> 1;
      e.isd = 0;
      e.tw  = 0;
      exp_q.push_back(e);
    end
    for (int k = 0; k < n_diff; k++) begin
      e.re = (fr_r[k] - fr_r[k+8]) >>> 1;
      e.im = (fr_i[k] - fr_i[k+8]) >>> 1;
      e.isd = 1;
      e.tw  = k;
      exp_q.push_back(e);
    end
  endtask

  task automatic watch();
    exp_t e;
    cyc++;
    if (out_valid) begin
      if (first_ov < 0) first_ov = cyc;
      run_len++;
      if (exp_q.size() == 0) begin
        check_eq("spurious_out_valid", out_valid, 0);
      end else begin
        e = exp_q.pop_front();
        check_eq("dout_r", dout_r, e.re);
        check_eq("dout_i", dout_i, e.im);
        check_eq("is_diff", is_diff, e.isd);
        check_eq("tw_idx", tw_idx, e.tw);
      end
    end else begin
      if (run_len > 0) last_run = run_len;
      run_len = 0;
    end
  endtask

  task automatic drive(input logic v, input longint r, input longint i);
    in_valid = v;
    din_r    = r[DW-1:0];
    din_i    = i[DW-1:0];
    #1;
    last_rdy = in_ready;
    last_den = delay_en;
    if (!in_ready) ready_low++;
    @(negedge clk);
    watch();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive(1'b0, 0, 0);
  endtask

  task automatic send_frame();
    for (int n = 0; n < 16; n++) drive(1'b1, fr_r[n], fr_i[n]);
  endtask

  task automatic rand_frame();
    logic signed [DW-1:0] t;
    for (int n = 0; n < 16; n++) begin
      t = DW'($urandom);
      fr_r[n] = t;
      t = DW'($urandom);
      fr_i[n] = t;
    end
  endtask

  task automatic begin_window();
    first_ov  = -1;
    run_len   = 0;
    last_run  = 0;
    ready_low = 0;
    start     = cyc;
  endtask

  task automatic frame_and_drain(input string tag);
    begin_window();
    rand_frame();
    push_frame(8);
    send_frame();
    idle(12);
    check_eq({tag, "_latency"}, first_ov - start, 9);
    check_eq({tag, "_run"}, last_run, 16);
    check_eq({tag, "_queue_left"}, exp_q.size(), 0);
  endtask

  initial begin
    int nf;
    rst_n = 1'b0; in_valid = 1'b0; din_r = '0; din_i = '0;
    @(negedge clk);

    // Reset held for two edges with in_valid high.
    for (int r = 0; r < 2; r++) begin
      drive(1'b1, 77, -5);
      check_eq("rst_in_ready", last_rdy, 1);
      check_eq("rst_delay_en", last_den, 0);
      check_eq("rst_out_valid", out_valid, 0);
      check_eq("rst_dout_r", dout_r, 0);
      check_eq("rst_dout_i", dout_i, 0);
      check_eq("rst_is_diff", is_diff, 0);
      check_eq("rst_tw_idx", tw_idx, 0);
      check_eq("rst_err", err, 0);
    end
    rst_n = 1'b1;
    idle(3);
    check_eq("idle_out_valid", out_valid, 0);

    // Ramp frame: sums 64..176, differences -64.
    for (int n = 0; n < 16; n++) begin
      fr_r[n] = 16 * n;
      fr_i[n] = 0;
    end
    begin_window();
    push_frame(8);
    send_frame();
    idle(12);
    check_eq("ramp_latency", first_ov - start, 9);
    check_eq("ramp_run", last_run, 16);
    check_eq("ramp_ready_low", ready_low, 8);
    check_eq("ramp_queue_left", exp_q.size(), 0);

    // Two back-to-back frames, second one constant 1000.
    begin_window();
    rand_frame();
    push_frame(8);
    send_frame();
    for (int n = 0; n < 16; n++) begin
      fr_r[n] = 1000;
      fr_i[n] = 0;
    end
    push_frame(8);
    send_frame();
    idle(12);
    check_eq("b2b_run", last_run, 32);
    check_eq("b2b_ready_low", ready_low, 8);
    check_eq("b2b_queue_left", exp_q.size(), 0);

    // Full-scale extremes.
    begin_window();
    rand_frame();
    fr_r[0] = -8388608; fr_r[8] = 8388607;
    fr_r[1] = 8388607;  fr_r[9] = 8388607;
    fr_i[0] = 8388607;  fr_i[8] = -8388608;
    fr_i[2] = -8388608; fr_i[10] = -8388608;
    push_frame(8);
    send_frame();
    idle(12);
    check_eq("ext_queue_left", exp_q.size(), 0);

    // Random bursts of 1..3 back-to-back frames.
    for (int t = 0; t < 5; t++) begin
      nf = $urandom_range(1, 3);
      begin_window();
      for (int f = 0; f < nf; f++) begin
        rand_frame();
        push_frame(8);
        send_frame();
      end
      idle(10 + $urandom_range(0, 4));
      check_eq("rnd_run", last_run, 16 * nf);
      check_eq("rnd_ready_low", ready_low, 8);
      check_eq("rnd_queue_left", exp_q.size(), 0);
    end

    // Drop at cnt=5 of a frame that is emitting the previous frame's differences.
    begin_window();
    rand_frame();
    push_frame(5);
    send_frame();
    rand_frame();
    for (int n = 0; n < 5; n++) drive(1'b1, fr_r[n], fr_i[n]);
    drive(1'b0, 0, 0);
    check_eq("drop_err", err, 1);
    check_eq("drop_out_valid", out_valid, 0);
    check_eq("drop_run", last_run, 13);
    idle(3);
    check_eq("drop_queue_left", exp_q.size(), 0);
    frame_and_drain("after_drop");
    check_eq("err_sticky", err, 1);
    rst_n = 1'b0;
    drive(1'b0, 0, 0);
    check_eq("err_cleared", err, 0);
    rst_n = 1'b1;
    idle(2);

    // in_valid high during flush is ignored.
    begin_window();
    rand_frame();
    push_frame(8);
    send_frame();
    drive(1'b0, 0, 0);
    for (int k = 0; k < 7; k++) drive(1'b1, $urandom, $urandom);
    idle(4);
    check_eq("flushvalid_err", err, 0);
    check_eq("flushvalid_ready_low", ready_low, 8);
    check_eq("flushvalid_run", last_run, 16);
    check_eq("flushvalid_queue_left", exp_q.size(), 0);
    frame_and_drain("after_flushvalid");

    // Reset during flush cycle 3.
    rand_frame();
    push_frame(8);
    send_frame();
    idle(3);
    rst_n = 1'b0;
    drive(1'b1, 123, 456);
    check_eq("flushrst_out_valid", out_valid, 0);
    check_eq("flushrst_dout_r", dout_r, 0);
    check_eq("flushrst_dout_i", dout_i, 0);
    check_eq("flushrst_is_diff", is_diff, 0);
    check_eq("flushrst_tw_idx", tw_idx, 0);
    check_eq("flushrst_queue_left", exp_q.size(), 5);
    exp_q.delete();
    rst_n = 1'b1;
    drive(1'b0, 0, 0);
    check_eq("flushrst_in_ready", last_rdy, 1);
    check_eq("flushrst_delay_en", last_den, 0);
    idle(2);
    frame_and_drain("after_flushrst");

    check_eq("final_queue_left", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sdf_bf_stage_8.md
Name: sdf_bf_stage_8

Overview:
- Radix-2 butterfly and control for the 8-deep stage of the 32-point single-path delay-feedback FFT.
- Pairs each incoming sample with the sample 8 positions earlier, read back from the external 8-entry delay line.
- Emits the scaled sum immediately and writes the scaled difference back into the delay line.
- Emits stored differences during the next half-frame, tagged with a twiddle index for the downstream multiplier.

Parameters:
- DW, 24, sample width per real/imag component; must match the delay-line width.
- HALF, 8, delay depth (half-frame length); fixed at 8 for this stage.

Ports:
- clk  input  1  clock
- rst_n  input  1  synchronous active-low reset
- in_valid  input  1  input sample valid
- in_ready  output  1  block accepts input (low during FLUSH)
- din_r  input  DW  signed input, real part
- din_i  input  DW  signed input, imaginary part
- delay_out_r  input  DW  delay-line tap, real (sample written HALF enabled cycles earlier)
- delay_out_i  input  DW  delay-line tap, imaginary
- delay_in_r  output  DW  combinational write data to delay line, real
- delay_in_i  output  DW  combinational write data to delay line, imaginary
- delay_en  output  1  delay-line shift enable
- out_valid  output  1  registered output valid
- dout_r  output  DW  registered output, real
- dout_i  output  DW  registered output, imaginary
- is_diff  output  1  current output is a difference term (needs twiddle)
- tw_idx  output  3  twiddle index for difference terms; 0 for sums
- err  output  1  sticky protocol error

Behaviour:
- Reset: synchronous on a clk edge with rst_n=0. All registered outputs become 0 (dout, out_valid, is_diff, tw_idx, err). Counter cnt[3:0]=0, primed=0, state=IDLE, in_ready=1. Reset overrides everything, including mid-RUN or mid-FLUSH.
- States:
  - IDLE: cnt=0. When in_valid=1, accept the sample (cnt becomes 1) and go to RUN.
  - RUN: cnt increments by 1 per accepted sample and wraps 15->0. primed is set when cnt wraps 15->0.
  - FLUSH: entered from RUN when in_valid=0 at cnt==0 with primed=1. Runs 8 cycles (cnt 0..7), then returns to IDLE with primed=0.
  - If in_valid=0 at cnt==0 with primed=0, stay in IDLE (no data).
- Mid-frame drop: in_valid=0 in RUN with cnt!=0 is a protocol error. Set err=1 (sticky until reset), go to IDLE, clear out_valid next edge, clear primed.
- in_ready=0 only in FLUSH. in_valid while in_ready=0 is ignored with no err.
- delay_en=1 on every cycle in RUN (accepted sample) or FLUSH, including the IDLE->RUN accept cycle; 0 otherwise.
- Arithmetic: form 25-bit signed sum S = delay_out + din and difference D = delay_out - din, then arithmetic shift right by 1 (floor). Each component handled independently.
- Phase on cnt[3] of the current (pre-increment) count:
  - cnt[3]=0 (fill): delay_in = din. Registered dout <= delay_out (stored difference), is_diff <= 1, tw_idx <= cnt[2:0], out_valid <= primed.
  - cnt[3]=1 (butterfly): delay_in = D>>>1. Registered dout <= S>>>1, is_diff <= 0, tw_idx <= 0, out_valid <= 1.
- FLUSH: treat din as 0. delay_in = 0, dout <= delay_out, is_diff <= 1, tw_idx <= cnt[2:0], out_valid <= 1.
- IDLE: delay_in = din. out_valid <= 0.
- Latency:
  - First sum appears one cycle after the 9th accepted sample, i.e. 9 cycles after the first sample.
  - Per frame, output is 8 sums then 8 differences, contiguous.
  - Back-to-back frames produce gap-free out_valid.

Test Plan:
- Reset: hold rst_n=0 for 2 edges with in_valid=1 -> all outputs 0, in_ready=1, delay_en=0, no state advance.
- Single frame: din_r=16n (n=0..15), din_i=0, contiguous.
  - Response: out_valid rises 9 cycles after the first sample and stays high 16 cycles.
  - First 8 outputs: dout_r=64,80,...,176 with is_diff=0.
  - Next 8 outputs: dout_r=-64 with is_diff=1, tw_idx=0..7.
  - in_ready=0 for exactly 8 cycles (FLUSH).
- Two back-to-back frames (second frame din_r=1000 constant) -> out_valid high 32 contiguous cycles; second-frame sums=1000, diffs=0.
- Extremes: x[0]=-8388608, x[8]=8388607 -> sum dout_r=-1, diff dout_r=-8388608. Both halves 8388607 -> sum 8388607, diff 0.
- in_valid dropped at cnt=5 -> err=1 next edge, out_valid=0, state IDLE; err stays 1 through a following valid frame until rst_n=0.
- in_valid=1 during FLUSH -> samples ignored, cnt unaffected, err=0. rst_n=0 at FLUSH cycle 3 -> all outputs 0 at that edge, in_ready=1.
